cache_tag_ctrl: RTL and testbench
=================================

Name: cache_tag_ctrl

Overview:
- Parametrised N-way set-associative cache directory: tag, valid, dirty and true-LRU state held in flops. No data array.
- Accepts READ / WRITE / INVALIDATE / FLUSH_ALL requests over a valid/ready handshake.
- Reports hit or miss, the selected way, the fill request, and the dirty-victim writeback address to the next-level memory controller.
- Write-back, write-allocate successor to the fixed 2-way instruction-fetch cache.

Parameters:
- ADDR_W, 32, byte address width.
- SETS, 16, number of sets; power of two, at least 2.
- WAYS, 4, associativity; power of two, at least 2.
- LINE_BYTES, 64, line size; power of two. Address fields: OFF = log2(LINE_BYTES), IDX = log2(SETS), TAG = ADDR_W-IDX-OFF.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  3  operation: 0 NOP, 1 READ, 2 WRITE, 3 INVALIDATE, 4 FLUSH_ALL; 5-7 treated as NOP.
- req_addr  in  ADDR_W  byte address.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  log2(WAYS)  way hit, allocated or invalidated.
- rsp_fill  out  1  line must be fetched from next level.
- rsp_evict  out  1  dirty line must be written back.
- rsp_evict_addr  out  ADDR_W  line address of writeback; offset bits are 0.
- hit_count  out  32  hit statistic (see Optional Feature).
- miss_count  out  32  miss statistic (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - All valid and dirty bits clear; way i age = i.
  - State IDLE; req_ready=1.
  - All rsp_* outputs 0; counters 0.
  - Reset mid-flush aborts the sweep; the block returns to IDLE.
- Handshake:
  - A request is accepted when req_valid && req_ready at a rising edge (cycle N).
  - Lookup is combinational from directory state; directory update and response register on the same edge.
  - rsp_valid is high for exactly cycle N+1.
  - Back-to-back requests are accepted every cycle. A request in N+1 sees the state written at N, including the same set.
  - NOP is accepted but produces no response.
- Lookup: hit = some way w has valid && tag == req_addr tag; rsp_way = w. At most one way matches.
- LRU: age 0 = MRU, age WAYS-1 = LRU; ages per set always form a permutation.
  - Touching way w with age a: every way with age < a increments, w becomes 0.
  - Hits and fills touch. INVALIDATE does not alter ages.
- Victim selection: lowest-index invalid way; otherwise the way with age WAYS-1.
- READ:
  - Hit: touch; rsp_fill=0.
  - Miss: allocate victim (tag written, valid=1, dirty=0), touch, rsp_fill=1, rsp_way=victim.
  - Victim previously valid && dirty: rsp_evict=1, rsp_evict_addr={old tag, index, OFF zeros}.
- WRITE: as READ, but the final dirty=1 (write-allocate). Hit: rsp_fill=0.
- INVALIDATE:
  - Hit: valid=0, dirty=0, rsp_hit=1; if the line was dirty, rsp_evict=1 with its address.
  - Miss: rsp_hit=0, no state change.
- FLUSH_ALL:
  - Enter SWEEP with req_ready=0.
  - Clear valid/dirty of one set per cycle, set 0 .. SETS-1, over SETS cycles. No writebacks.
  - Counters clear.
  - Then IDLE; rsp_valid pulses with rsp_hit=0 in the cycle after the last set clears; req_ready=1 the same cycle.
- States: IDLE (ready=1), SWEEP (ready=0, set counter of IDX bits). SWEEP -> IDLE when the counter reaches SETS-1.
- rsp_* fields other than rsp_valid are 0 whenever rsp_valid=0.

Optional Feature:
- Macro CACHE_TAG_STATS_EN.
- Defined: hit_count increments on a READ/WRITE hit; miss_count increments on a READ/WRITE miss. Counters are 32-bit saturating at 0xFFFF_FFFF and cleared by reset and FLUSH_ALL. INVALIDATE does not count.
- Undefined: counter logic is absent; hit_count and miss_count are tied to 0.

Test Plan:
- After reset, READ 0x0000_1000 -> at N+1: rsp_valid=1, hit=0, fill=1, way=0, evict=0. Repeat READ -> hit=1, way=0, fill=0.
- WRITE 0x0, 0x400, 0x800, 0xC00 (all index 0), then READ 0x1000 -> miss, way=0, evict=1, evict_addr=0x0000_0000.
- READ 0x0, 0x400, 0x800, 0xC00, READ 0x0 again, then READ 0x1000 -> victim way=1, evict=0 (clean).
- WRITE 0x2040 then INVALIDATE 0x2040 -> hit=1, evict=1, evict_addr=0x0000_2040. Next READ 0x2040 -> miss, fill=1.
- FLUSH_ALL issued with lines valid -> req_ready=0 for 16 cycles, then rsp_valid. Subsequent READs of previously cached addresses all miss; counters 0.
- Assert reset_n low at sweep cycle 5 -> req_ready=1 and all rsp_* 0 immediately. With CACHE_TAG_STATS_EN, 3 hits + 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/cache_tag_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_tag_ctrl_if
// Description : Request/response bundle between a requester and the
//               cache_tag_ctrl directory (valid/ready request side plus a
//               one-cycle response strobe with lookup results).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_tag_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 4
) ();
  localparam int c_WAY_W = $clog2(WAYS);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [c_WAY_W-1:0] rsp_way;
  logic              rsp_fill;
  logic              rsp_evict;
  logic [ADDR_W-1:0] rsp_evict_addr;

  // Requester side: issues operations and consumes responses
  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_fill, rsp_evict, rsp_evict_addr
  );

  // Directory side
  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_fill, rsp_evict, rsp_evict_addr
  );
endinterface
`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_tag_ctrl
// Description : N-way set-associative cache directory (tag/valid/dirty and
//               true-LRU ages in flops, no data array). Handles READ, WRITE,
//               INVALIDATE and FLUSH_ALL; write-back, write-allocate.
//               Optional hit/miss statistics under macro CACHE_TAG_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_tag_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  cache_tag_ctrl_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int c_OFF_W = $clog2(LINE_BYTES);
  localparam int c_IDX_W = $clog2(SETS);
  localparam int c_TAG_W = ADDR_W - c_IDX_W - c_OFF_W;
  localparam int c_WAY_W = $clog2(WAYS);

  localparam logic [2:0] c_OP_READ  = 3'd1;
  localparam logic [2:0] c_OP_WRITE = 3'd2;
  localparam logic [2:0] c_OP_INVAL = 3'd3;
  localparam logic [2:0] c_OP_FLUSH = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Directory storage
  logic [c_TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [c_WAY_W-1:0] r_age   [SETS][WAYS];

  // Control and registered response
  state_t             r_state;
  logic [c_IDX_W-1:0] r_sweep_idx;
  logic               r_ready;
  logic               r_rsp_valid;
  logic               r_rsp_hit;
  logic [c_WAY_W-1:0] r_rsp_way;
  logic               r_rsp_fill;
  logic               r_rsp_evict;
  logic [ADDR_W-1:0]  r_rsp_evict_addr;

  // Lookup results
  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;
  logic               w_accept;
  logic               w_is_rw;
  logic               w_is_write;
  logic               w_hit;
  logic [c_WAY_W-1:0] w_hit_way;
  logic               w_inv_found;
  logic [c_WAY_W-1:0] w_inv_way;
  logic [c_WAY_W-1:0] w_lru_way;
  logic [c_WAY_W-1:0] w_victim;
  logic [c_WAY_W-1:0] w_touch_way;
  logic [c_WAY_W-1:0] w_touch_age;
  logic [c_WAY_W-1:0] w_new_age [WAYS];
  logic [c_TAG_W-1:0] w_vic_tag;
  logic               w_vic_dirty;
  logic               w_hit_dirty;
  logic               w_unused_off;

  assign w_idx        = bus.req_addr[c_OFF_W +: c_IDX_W];
  assign w_tag        = bus.req_addr[ADDR_W-1 -: c_TAG_W];
  assign w_unused_off = ^bus.req_addr[c_OFF_W-1:0];
  assign w_accept     = bus.req_valid && r_ready;
  assign w_is_write   = (bus.req_op == c_OP_WRITE);
  assign w_is_rw      = (bus.req_op == c_OP_READ) || w_is_write;

  // Tag match, first invalid way and LRU way of the addressed set
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = c_WAY_W'(w);
      end
      if (r_age[w_idx][w] == c_WAY_W'(WAYS - 1)) begin
        w_lru_way = c_WAY_W'(w);
      end
    end
  end

  assign w_victim    = w_inv_found ? w_inv_way : w_lru_way;
  assign w_touch_way = w_hit ? w_hit_way : w_victim;
  assign w_touch_age = r_age[w_idx][w_touch_way];
  assign w_vic_tag   = r_tag[w_idx][w_victim];
  assign w_vic_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  assign w_hit_dirty = r_dirty[w_idx][w_hit_way];

  // Ages after touching w_touch_way: younger ways age by one, touched way becomes MRU
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_new_age[w] = r_age[w_idx][w];
      if (c_WAY_W'(w) == w_touch_way) begin
        w_new_age[w] = '0;
      end else if (r_age[w_idx][w] < w_touch_age) begin
        w_new_age[w] = r_age[w_idx][w] + c_WAY_W'(1);
      end
    end
  end

  // Control FSM: directory update, flush sweep and registered response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          r_age[s][w] <= c_WAY_W'(w);
        end
      end
      r_state          <= ST_IDLE;
      r_sweep_idx      <= '0;
      r_ready          <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_rsp_hit        <= 1'b0;
      r_rsp_way        <= '0;
      r_rsp_fill       <= 1'b0;
      r_rsp_evict      <= 1'b0;
      r_rsp_evict_addr <= '0;
    end else begin
      r_rsp_valid      <= 1'b0;
      r_rsp_hit        <= 1'b0;
      r_rsp_way        <= '0;
      r_rsp_fill       <= 1'b0;
      r_rsp_evict      <= 1'b0;
      r_rsp_evict_addr <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.req_op)
              c_OP_READ, c_OP_WRITE: begin
                r_rsp_valid <= 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                  r_age[w_idx][w] <= w_new_age[w];
                end
                if (w_hit) begin
                  r_rsp_hit <= 1'b1;
                  r_rsp_way <= w_hit_way;
                  if (w_is_write) begin
                    r_dirty[w_idx][w_hit_way] <= 1'b1;
                  end
                end else begin
                  r_rsp_way                <= w_victim;
                  r_rsp_fill               <= 1'b1;
                  r_tag[w_idx][w_victim]   <= w_tag;
                  r_valid[w_idx][w_victim] <= 1'b1;
                  r_dirty[w_idx][w_victim] <= w_is_write;
                  r_rsp_evict              <= w_vic_dirty;
                  if (w_vic_dirty) begin
                    r_rsp_evict_addr <= {w_vic_tag, w_idx, {c_OFF_W{1'b0}}};
                  end
                end
              end
              c_OP_INVAL: begin
                r_rsp_valid <= 1'b1;
                if (w_hit) begin
                  r_rsp_hit                 <= 1'b1;
                  r_rsp_way                 <= w_hit_way;
                  r_valid[w_idx][w_hit_way] <= 1'b0;
                  r_dirty[w_idx][w_hit_way] <= 1'b0;
                  r_rsp_evict               <= w_hit_dirty;
                  if (w_hit_dirty) begin
                    r_rsp_evict_addr <= {w_tag, w_idx, {c_OFF_W{1'b0}}};
                  end
                end
              end
              c_OP_FLUSH: begin
                r_state     <= ST_SWEEP;
                r_ready     <= 1'b0;
                r_sweep_idx <= '0;
              end
              default: begin
              end
            endcase
          end
        end
        ST_SWEEP: begin
          r_valid[r_sweep_idx] <= '0;
          r_dirty[r_sweep_idx] <= '0;
          if (r_sweep_idx == c_IDX_W'(SETS - 1)) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b1;
          end else begin
            r_sweep_idx <= r_sweep_idx + c_IDX_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_hit        = r_rsp_hit;
  assign bus.rsp_way        = r_rsp_way;
  assign bus.rsp_fill       = r_rsp_fill;
  assign bus.rsp_evict      = r_rsp_evict;
  assign bus.rsp_evict_addr = r_rsp_evict_addr;

`ifdef CACHE_TAG_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating hit/miss statistics; a flush clears them
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept && (bus.req_op == c_OP_FLUSH)) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept && w_is_rw) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_tag_ctrl
// Description : Self-checking bench for cache_tag_ctrl. A reference directory
//               model predicts each response when a request is accepted; the
//               monitor pops and compares it in the cycle it must appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_tag_ctrl;
  localparam int SETS = 16;
  localparam int WAYS = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_FLUSH = 3'd4;

  typedef struct {
    int          due;
    bit          hit;
    int          way;
    bit          fill;
    bit          evict;
    logic [31:0] eaddr;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  // Reference directory
  int m_tag [SETS][WAYS];
  bit m_val [SETS][WAYS];
  bit m_dty [SETS][WAYS];
  int m_age [SETS][WAYS];
  int m_hits;
  int m_miss;

  cache_tag_ctrl_if #(.ADDR_W(32), .WAYS(WAYS)) bus ();

  cache_tag_ctrl #(
    .ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(64)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = 0; m_val[s][w] = 0; m_dty[s][w] = 0; m_age[s][w] = w;
      end
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    int a;
    a = m_age[s][w];
    for (int v = 0; v < WAYS; v++)
      if (v == w) m_age[s][v] = 0;
      else if (m_age[s][v] < a) m_age[s][v] = m_age[s][v] + 1;
  endtask

  // Called right after the accepting edge; predicts the response and updates the model
  task automatic model_access(input logic [2:0] op, input logic [31:0] addr);
    exp_t e;
    int   s, tg, hw, v;
    e = '{due: cyc, hit: 0, way: 0, fill: 0, evict: 0, eaddr: 32'h0};
    s  = int'((addr >> 6) & 32'hF);
    tg = int'(addr >> 10);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_val[s][w] && m_tag[s][w] == tg) hw = w;
    case (op)
      OP_READ, OP_WRITE: begin
        if (hw >= 0) begin
          e.hit = 1; e.way = hw;
          if (op == OP_WRITE) m_dty[s][hw] = 1;
          model_touch(s, hw);
          m_hits++;
        end else begin
          v = -1;
          for (int w = WAYS - 1; w >= 0; w--) if (!m_val[s][w]) v = w;
          if (v < 0) for (int w = 0; w < WAYS; w++) if (m_age[s][w] == WAYS - 1) v = w;
          e.way = v; e.fill = 1;
          if (m_val[s][v] && m_dty[s][v]) begin
            e.evict = 1;
            e.eaddr = (32'(m_tag[s][v]) << 10) | (32'(s) << 6);
          end
          m_tag[s][v] = tg; m_val[s][v] = 1; m_dty[s][v] = (op == OP_WRITE);
          model_touch(s, v);
          m_miss++;
        end
        sb.push_back(e);
      end
      OP_INVAL: begin
        if (hw >= 0) begin
          e.hit = 1; e.way = hw;
          if (m_dty[s][hw]) begin e.evict = 1; e.eaddr = addr & 32'hFFFF_FFC0; end
          m_val[s][hw] = 0; m_dty[s][hw] = 0;
        end
        sb.push_back(e);
      end
      OP_FLUSH: begin
        for (int i = 0; i < SETS; i++)
          for (int w = 0; w < WAYS; w++) begin m_val[i][w] = 0; m_dty[i][w] = 0; end
        m_hits = 0; m_miss = 0;
        e.due = cyc + SETS;
        sb.push_back(e);
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!bus.req_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.req_op    = OP_NOP;
      model_access(op, addr);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_counters(input string tag);
`ifdef CACHE_TAG_STATS_EN
    check({tag, "_hits"}, hit_count, m_hits);
    check({tag, "_miss"}, miss_count, m_miss);
`else
    check({tag, "_hits"}, hit_count, 0);
    check({tag, "_miss"}, miss_count, 0);
`endif
  endtask

  // Flush, then confirm ready stays low for exactly one cycle per set
  task automatic flush_and_count();
    int low;
    low = 0;
    issue(OP_FLUSH, 32'h0);
    while (low < 64) begin
      @(negedge clock);
      if (bus.req_ready) break;
      low++;
    end
    check("flush_ready_low_cycles", low, SETS);
  endtask

  // Response monitor: every cycle must match the scoreboard head's due cycle
  always @(negedge clock) begin : mon
    exp_t e;
    bit   ev;
    if (reset_n) begin
      ev = (sb.size() > 0) && (sb[0].due == cyc);
      check("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        e = sb.pop_front();
        check("rsp_hit", bus.rsp_hit, e.hit);
        check("rsp_way", bus.rsp_way, e.way);
        check("rsp_fill", bus.rsp_fill, e.fill);
        check("rsp_evict", bus.rsp_evict, e.evict);
        check("rsp_evict_addr", bus.rsp_evict_addr, e.eaddr);
      end else begin
        check("rsp_idle_zero", {bus.rsp_hit, bus.rsp_way, bus.rsp_fill, bus.rsp_evict, bus.rsp_evict_addr}, 0);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    logic [2:0]  op;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_addr  = 32'h0;
    reset_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check_counters("reset");
    reset_n = 1'b1;

    // Cold miss then hit on the same line
    issue(OP_READ, 32'h0000_1000);
    issue(OP_READ, 32'h0000_1000);

    // Fill set 0 with dirty lines, then force a dirty eviction of way 0
    do_reset();
    issue(OP_WRITE, 32'h0000_0000);
    issue(OP_WRITE, 32'h0000_0400);
    issue(OP_WRITE, 32'h0000_0800);
    issue(OP_WRITE, 32'h0000_0C00);
    issue(OP_READ,  32'h0000_1000);

    // Clean lines; re-touching way 0 makes way 1 the victim
    do_reset();
    issue(OP_READ, 32'h0000_0000);
    issue(OP_READ, 32'h0000_0400);
    issue(OP_READ, 32'h0000_0800);
    issue(OP_READ, 32'h0000_0C00);
    issue(OP_READ, 32'h0000_0000);
    issue(OP_READ, 32'h0000_1000);

    // Invalidate of a dirty line reports writeback; later read misses
    issue(OP_WRITE, 32'h0000_2040);
    issue(OP_INVAL, 32'h0000_2040);
    issue(OP_READ,  32'h0000_2040);
    issue(OP_INVAL, 32'h0000_5040);
    issue(OP_NOP,   32'h0000_2040);
    issue(3'd6,     32'h0000_2040);

    // Flush with valid lines; previously cached lines now miss
    flush_and_count();
    check_counters("after_flush");
    issue(OP_READ, 32'h0000_0000);
    issue(OP_READ, 32'h0000_0800);
    issue(OP_READ, 32'h0000_1000);

    // Reset in the middle of a sweep
    issue(OP_FLUSH, 32'h0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midsweep_ready", bus.req_ready, 1);
    check("midsweep_rsp", {bus.rsp_valid, bus.rsp_hit, bus.rsp_fill, bus.rsp_evict, bus.rsp_evict_addr}, 0);
    check("midsweep_hits", hit_count, 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Statistics: 3 hits, 2 misses
    issue(OP_READ, 32'h0000_3000);
    issue(OP_READ, 32'h0000_3000);
    issue(OP_READ, 32'h0000_3000);
    issue(OP_READ, 32'h0000_3400);
    issue(OP_READ, 32'h0000_3400);
    check_counters("stats");

    // Random traffic over a few tags in two sets
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      op = OP_READ;
      else if (r < 75) op = OP_WRITE;
      else if (r < 88) op = OP_INVAL;
      else if (r < 90) op = OP_FLUSH;
      else if (r < 94) op = OP_NOP;
      else             op = 3'(5 + (r % 3));
      a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 1)) << 6) | 32'($urandom_range(0, 63));
      issue(op, a);
    end
    check_counters("random_end");

    // Let outstanding responses drain
    repeat (SETS + 4) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
